vreg_group_collector: RTL and testbench
=======================================

Name: vreg_group_collector

Overview:
- Write-back side counterpart of the vector register-group address generator.
- Records each issued register group `{group address, vlmul}` in a small in-order queue.
- Consumes the per-register write-back beats the datapath produces and checks that each beat hits the expected physical register.
- Pulses a completion for the group once its last register is written; the scheduler uses this to release hazards on the group.

Parameters:
- ADDR_WIDTH, 5, width of group and physical vector-register addresses (32 registers).
- DEPTH, 4, number of outstanding groups; power of 2, at least 2.

Ports:
- clk  input  1  clock.
- rst  input  1  reset; synchronous, active-high.
- issue_valid  input  1  group issued this cycle.
- issue_ready  output  1  queue can accept a group.
- issue_addr  input  ADDR_WIDTH  register-group address.
- issue_vlmul  input  3  vlmul of the group.
- wb_valid  input  1  one register write-back beat.
- wb_addr  input  ADDR_WIDTH  physical register written.
- done_valid  output  1  one-cycle group-complete pulse.
- done_addr  output  ADDR_WIDTH  group address of the completed group, as issued.
- done_vlmul  output  3  vlmul of the completed group.
- err  output  1  sticky protocol error.
- err_clr  input  1  clears err.
- busy  output  1  queue non-empty.

Behaviour:
- Reset (rst=1 at posedge):
  - Queue emptied, beat counter set to 0.
  - done_valid=0, done_addr=0, done_vlmul=0, err=0.
  - issue_ready=1, busy=0.
  - Reset mid-group discards all in-flight state; no done is produced for discarded groups.
- Group geometry:
  - vlmul 0..3: size = 1<<vlmul; base = (addr<<vlmul) truncated to ADDR_WIDTH.
  - vlmul 4..7 (fractional): size = 1; base = addr.
- Issue:
  - issue_ready = !full, combinational from registered occupancy.
  - Enqueue when issue_valid && issue_ready.
  - issue_valid while not ready is ignored; the upstream block must hold it.
- Head entry:
  - expected = base(head) + beat_cnt, ADDR_WIDTH arithmetic.
  - beat_cnt runs 0..size-1.
- wb beat with queue empty:
  - err set next cycle; beat dropped; no other state change.
  - No bypass: an issue and a wb in the same cycle with an empty queue is an error.
- wb beat with queue non-empty:
  - If wb_addr != expected, err is set; the beat is still counted so the group stays aligned.
  - If beat_cnt == size-1: pop head, beat_cnt <- 0; next cycle done_valid=1 with the head's addr and vlmul.
  - Otherwise beat_cnt <- beat_cnt+1.
- done_valid:
  - Registered; latency is 1 cycle after the last beat.
  - High for exactly one cycle per group.
  - done_addr and done_vlmul hold their last values when done_valid is low.
- Simultaneous issue and pop:
  - Both take effect; occupancy is unchanged.
  - When full, issue_ready=0 that cycle even if a pop occurs (no same-cycle refill).
- err:
  - Sticky; cleared by err_clr.
  - If err_clr and a new error occur in the same cycle, set wins.
- busy = queue non-empty.
- Pointers wrap modulo DEPTH; occupancy counter is clog2(DEPTH)+1 bits.
- FSM:
  - IDLE (empty) -> COLLECT on enqueue.
  - COLLECT -> IDLE when the last beat pops the only entry and there is no simultaneous issue.
  - COLLECT stays COLLECT otherwise.

Decomposition:
- Package vreg_group_pkg:
  - Constants VLMUL_FRAC_MIN=3'b100 and vlmul field width.
  - Functions group_size(vlmul) and group_base(addr, vlmul).
  - Typedef of the group entry struct `{addr, vlmul}`.
- Sub-module vreg_group_fifo:
  - Synchronous FIFO of group entries with push/pop/full/empty.
  - Parameterised by DEPTH and entry width.
- Collector top: beat counter, comparison, done/err registers, FSM.

Test Plan:
1. Issue addr=3, vlmul=2; wb 12,13,14,15 on consecutive cycles -> done_valid one cycle after the 15 beat, done_addr=3, done_vlmul=2, err=0, busy=0 afterwards.
2. Issue addr=7, vlmul=5; wb 7 -> done pulse with done_addr=7, done_vlmul=5; a second wb 7 afterwards -> err=1 (empty queue), no done.
3. Issue 4 groups of addr=1, vlmul=0 -> issue_ready=0 with a 5th issue held. Then wb 1 -> pop; issue_ready=1 next cycle; held issue accepted, occupancy 4.
4. Issue addr=2, vlmul=1; wb 4 then 6 -> err=1, done still pulses for addr=2. Assert err_clr -> err=0 next cycle.
5. Issue addr=5, vlmul=3 -> base truncates 40 to 8; wb 8..15 -> done_addr=5, no err.
6. Issue addr=1, vlmul=2; wb 4,5; assert rst -> all outputs 0, issue_ready=1, busy=0. Next wb 6 -> err=1.

Source files
------------

// File: rtl/vreg_group_pkg.sv
// Shared types and group-geometry helpers for the vector register-group write-back collector.
package vreg_group_pkg;

  localparam int VLMUL_W = 3;
  localparam logic [VLMUL_W-1:0] VLMUL_FRAC_MIN = 3'b100;
  // Widest supported register address; narrower collectors zero-extend into it.
  localparam int ADDR_W_MAX = 8;

  typedef struct packed {
    logic [ADDR_W_MAX-1:0] addr;
    logic [VLMUL_W-1:0]    vlmul;
  } grp_entry_t;

  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } col_state_t;

  // Registers in the group: 1,2,4,8 for integral vlmul, 1 for fractional.
  function automatic logic [3:0] group_size(input logic [VLMUL_W-1:0] vlmul);
    if (vlmul >= VLMUL_FRAC_MIN) return 4'd1;
    return 4'd1 << vlmul[1:0];
  endfunction

  function automatic logic [ADDR_W_MAX-1:0] group_base(input grp_entry_t e);
    if (e.vlmul >= VLMUL_FRAC_MIN) return e.addr;
    return e.addr << e.vlmul[1:0];
  endfunction

endpackage

// File: rtl/vreg_group_fifo.sv
// In-order queue of issued groups; push/pop same cycle allowed, zero-latency head view.
// The caller gates push with !full and pop with !empty.
module vreg_group_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  assign head  = mem[rd_ptr];
  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  // DEPTH is a power of two, so the pointers wrap on natural overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/vreg_group_collector.sv
// Tracks issued register groups, checks write-back beats in order, pulses done 1 cycle after the last beat.
// issue_ready = !full from registered occupancy; no same-cycle refill when full.
module vreg_group_collector
  import vreg_group_pkg::*;
#(
  parameter int ADDR_WIDTH = 5,
  parameter int DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  issue_valid,
  output logic                  issue_ready,
  input  logic [ADDR_WIDTH-1:0] issue_addr,
  input  logic [VLMUL_W-1:0]    issue_vlmul,
  input  logic                  wb_valid,
  input  logic [ADDR_WIDTH-1:0] wb_addr,
  output logic                  done_valid,
  output logic [ADDR_WIDTH-1:0] done_addr,
  output logic [VLMUL_W-1:0]    done_vlmul,
  output logic                  err,
  input  logic                  err_clr,
  output logic                  busy
);

  localparam int EW = ADDR_WIDTH + VLMUL_W;
  localparam logic [ADDR_W_MAX-1:0] ADDR_MASK = ADDR_W_MAX'((1 << ADDR_WIDTH) - 1);

  logic                     full;
  logic                     empty;
  logic [$clog2(DEPTH):0]   count;
  logic [EW-1:0]            head_raw;
  logic [ADDR_WIDTH-1:0]    head_addr;
  logic [VLMUL_W-1:0]       head_vlmul;
  grp_entry_t               head_e;
  logic [3:0]               head_size;
  logic [ADDR_W_MAX-1:0]    expected;
  logic [2:0]               beat_cnt;
  logic                     push;
  logic                     pop;
  logic                     beat_last;
  logic                     err_set;
  col_state_t               state;
  col_state_t               state_nxt;

  assign issue_ready = !full;
  assign push        = issue_valid && issue_ready;

  vreg_group_fifo #(.DEPTH(DEPTH), .WIDTH(EW)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data ({issue_addr, issue_vlmul}),
    .pop       (pop),
    .head      (head_raw),
    .full      (full),
    .empty     (empty),
    .count     (count)
  );

  assign {head_addr, head_vlmul} = head_raw;
  assign head_e.addr  = ADDR_W_MAX'(head_addr);
  assign head_e.vlmul = head_vlmul;
  assign head_size    = group_size(head_e.vlmul);
  // Masking keeps the sum in ADDR_WIDTH arithmetic, so wrap-around bases compare correctly.
  assign expected     = (group_base(head_e) + ADDR_W_MAX'(beat_cnt)) & ADDR_MASK;

  // Mismatched beats still advance the counter to keep later beats aligned.
  assign beat_last = ({1'b0, beat_cnt} == head_size - 4'd1);
  assign pop       = wb_valid && !empty && beat_last;
  assign err_set   = wb_valid && (empty || (ADDR_W_MAX'(wb_addr) != expected));

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      beat_cnt   <= '0;
      done_valid <= 1'b0;
      done_addr  <= '0;
      done_vlmul <= '0;
      err        <= 1'b0;
    end else begin
      state      <= state_nxt;
      done_valid <= pop;
      if (pop) begin
        done_addr  <= head_addr;
        done_vlmul <= head_vlmul;
      end
      if (wb_valid && !empty) beat_cnt <= beat_last ? 3'd0 : beat_cnt + 3'd1;
      if (err_set)      err <= 1'b1;
      else if (err_clr) err <= 1'b0;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (push) state_nxt = COLLECT;
      COLLECT: if (pop && !push && count == 1) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state == COLLECT);

endmodule

// File: tb/tb_vreg_group_collector.sv
// Directed bench for vreg_group_collector with hand-computed expectations.
module tb_vreg_group_collector;

  logic       clk = 1'b0;
  logic       rst;
  logic       issue_valid;
  logic       issue_ready;
  logic [4:0] issue_addr;
  logic [2:0] issue_vlmul;
  logic       wb_valid;
  logic [4:0] wb_addr;
  logic       done_valid;
  logic [4:0] done_addr;
  logic [2:0] done_vlmul;
  logic       err;
  logic       err_clr;
  logic       busy;

  int total = 0;
  int bad   = 0;
  int dones;

  vreg_group_collector #(.ADDR_WIDTH(5), .DEPTH(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .issue_valid (issue_valid),
    .issue_ready (issue_ready),
    .issue_addr  (issue_addr),
    .issue_vlmul (issue_vlmul),
    .wb_valid    (wb_valid),
    .wb_addr     (wb_addr),
    .done_valid  (done_valid),
    .done_addr   (done_addr),
    .done_vlmul  (done_vlmul),
    .err         (err),
    .err_clr     (err_clr),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; issue_valid = 0; issue_addr = 0; issue_vlmul = 0;
    wb_valid = 0; wb_addr = 0; err_clr = 0;
    tick();
    rst = 1'b0;
    chk("rst_done_valid", done_valid, 0);
    chk("rst_done_addr", done_addr, 0);
    chk("rst_err", err, 0);
    chk("rst_issue_ready", issue_ready, 1);
    chk("rst_busy", busy, 0);

    // 1: addr 3, vlmul 2 -> regs 12..15
    issue_valid = 1; issue_addr = 3; issue_vlmul = 2;
    tick();
    issue_valid = 0;
    chk("t1_busy", busy, 1);
    wb_valid = 1;
    for (int i = 12; i <= 14; i++) begin
      wb_addr = 5'(i);
      tick();
      chk("t1_no_done_mid", done_valid, 0);
    end
    wb_addr = 15;
    tick();
    wb_valid = 0;
    chk("t1_done", done_valid, 1);
    chk("t1_done_addr", done_addr, 3);
    chk("t1_done_vlmul", done_vlmul, 2);
    chk("t1_err", err, 0);
    chk("t1_busy_after", busy, 0);
    tick();
    chk("t1_done_pulse", done_valid, 0);
    chk("t1_done_addr_hold", done_addr, 3);

    // 2: fractional vlmul, then beat on empty queue
    issue_valid = 1; issue_addr = 7; issue_vlmul = 5;
    tick();
    issue_valid = 0;
    wb_valid = 1; wb_addr = 7;
    tick();
    chk("t2_done", done_valid, 1);
    chk("t2_done_addr", done_addr, 7);
    chk("t2_done_vlmul", done_vlmul, 5);
    tick();
    wb_valid = 0;
    chk("t2_err_empty", err, 1);
    chk("t2_no_done", done_valid, 0);
    err_clr = 1;
    tick();
    err_clr = 0;
    chk("t2_err_clr", err, 0);

    // 3: fill queue, held 5th issue, pop frees a slot
    issue_valid = 1; issue_addr = 1; issue_vlmul = 0;
    for (int i = 0; i < 4; i++) tick();
    chk("t3_full_not_ready", issue_ready, 0);
    tick();
    chk("t3_held_not_ready", issue_ready, 0);
    wb_valid = 1; wb_addr = 1;
    tick();
    wb_valid = 0;
    chk("t3_pop_done", done_valid, 1);
    chk("t3_ready_after_pop", issue_ready, 1);
    tick();
    issue_valid = 0;
    chk("t3_refilled_full", issue_ready, 0);
    dones = 0;
    wb_valid = 1; wb_addr = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (done_valid) dones++;
    end
    wb_valid = 0;
    chk("t3_drain_dones", dones, 4);
    chk("t3_drain_busy", busy, 0);
    chk("t3_drain_err", err, 0);

    // 4: mismatched beat still completes the group
    issue_valid = 1; issue_addr = 2; issue_vlmul = 1;
    tick();
    issue_valid = 0;
    wb_valid = 1; wb_addr = 4;
    tick();
    chk("t4_first_ok", err, 0);
    wb_addr = 6;
    tick();
    wb_valid = 0;
    chk("t4_err", err, 1);
    chk("t4_done", done_valid, 1);
    chk("t4_done_addr", done_addr, 2);
    err_clr = 1;
    tick();
    chk("t4_err_clr", err, 0);
    wb_valid = 1; wb_addr = 0;
    tick();
    wb_valid = 0; err_clr = 0;
    chk("t4_set_wins", err, 1);
    err_clr = 1;
    tick();
    err_clr = 0;
    chk("t4_err_clr2", err, 0);

    // 5: vlmul 3 base 40 truncates to 8
    issue_valid = 1; issue_addr = 5; issue_vlmul = 3;
    tick();
    issue_valid = 0;
    wb_valid = 1;
    for (int i = 8; i <= 14; i++) begin
      wb_addr = 5'(i);
      tick();
    end
    chk("t5_no_early_done", done_valid, 0);
    wb_addr = 15;
    tick();
    wb_valid = 0;
    chk("t5_done", done_valid, 1);
    chk("t5_done_addr", done_addr, 5);
    chk("t5_done_vlmul", done_vlmul, 3);
    chk("t5_err", err, 0);

    // simultaneous issue and last-beat pop keeps the collector busy
    issue_valid = 1; issue_addr = 9; issue_vlmul = 0;
    tick();
    issue_addr = 10; wb_valid = 1; wb_addr = 9;
    tick();
    issue_valid = 0;
    chk("sim_done_addr", done_addr, 9);
    chk("sim_busy", busy, 1);
    wb_addr = 10;
    tick();
    wb_valid = 0;
    chk("sim_done2_addr", done_addr, 10);
    chk("sim_busy_after", busy, 0);
    chk("sim_err", err, 0);

    // 6: reset mid-group discards state
    issue_valid = 1; issue_addr = 1; issue_vlmul = 2;
    tick();
    issue_valid = 0;
    wb_valid = 1; wb_addr = 4;
    tick();
    wb_addr = 5;
    tick();
    wb_valid = 0; rst = 1;
    tick();
    rst = 0;
    chk("t6_done_valid", done_valid, 0);
    chk("t6_done_addr", done_addr, 0);
    chk("t6_done_vlmul", done_vlmul, 0);
    chk("t6_err", err, 0);
    chk("t6_ready", issue_ready, 1);
    chk("t6_busy", busy, 0);
    wb_valid = 1; wb_addr = 6;
    tick();
    wb_valid = 0;
    chk("t6_err_after", err, 1);
    chk("t6_no_done", done_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
